// File: rtl/shooter_core.sv
// rtl/shooter_core.sv - game-play engine for the VGA shooter
//
// Purpose: gun, a pool of NUM_BUL bullets, one falling obstacle, BCD score,
// lives, level and the game FSM. All object motion happens on the frame tick
// (the last visible pixel). The object pixel colour is registered (one clock
// behind x/y).
//
// Optional feature: define SHOOTER_AUTOFIRE_EN to make a held fire key raise
// a shot every AUTO_PER frames in PLAY.
//
// Ports:
//   clk        pixel clock
//   rst        asynchronous active-high reset
//   x, y       current pixel coordinate from the sync counter
//   key        held key code (5'h11 right, 5'h13 left, 5'h15 fire, [4] start)
//   key_pulse  one-clock pulse of key on press
//   rgb        registered object colour
//   score_bcd  BCD score, digit 0 in [3:0]
//   life       remaining lives
//   level      current level 0..3
//   state      FSM state (00 NEWGAME, 01 PLAY, 10 NEWGUN, 11 OVER)
//   game_over  high in OVER
module shooter_core #(
  parameter int MAX_X    = 640,
  parameter int MAX_Y    = 480,
  parameter int GUN_W    = 50,
  parameter int GUN_Y_T  = 420,
  parameter int GUN_Y_B  = 470,
  parameter int GUN_V    = 4,
  parameter int NUM_BUL  = 4,
  parameter int BUL_W    = 4,
  parameter int BUL_H    = 8,
  parameter int BUL_V    = 8,
  parameter int OBS_W    = 32,
  parameter int OBS_H    = 16,
  parameter int OBS_V0   = 1,
  parameter int LIVES    = 3,
  parameter int DIGITS   = 2,
  parameter int AUTO_PER = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic [4:0]            key,
  input  logic [4:0]            key_pulse,
  output logic [2:0]            rgb,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [1:0]            life,
  output logic [1:0]            level,
  output logic [1:0]            state,
  output logic                  game_over
);

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWGUN  = 2'b10,
    ST_OVER    = 2'b11
  } state_t;

  localparam logic [9:0] C_XLAST     = 10'(MAX_X - 1);
  localparam logic [9:0] C_YLAST     = 10'(MAX_Y - 1);
  localparam logic [9:0] C_GUN_X0    = 10'((MAX_X - GUN_W) / 2);
  localparam logic [9:0] C_GUN_W1    = 10'(GUN_W - 1);
  localparam logic [9:0] C_GUN_V     = 10'(GUN_V);
  localparam logic [9:0] C_GUN_YT    = 10'(GUN_Y_T);
  localparam logic [9:0] C_GUN_YB    = 10'(GUN_Y_B);
  localparam logic [9:0] C_BUL_XOFF  = 10'((GUN_W - BUL_W) / 2);
  localparam logic [9:0] C_BUL_TOP0  = 10'(GUN_Y_T - BUL_H);
  localparam logic [9:0] C_BUL_W1    = 10'(BUL_W - 1);
  localparam logic [9:0] C_BUL_H1    = 10'(BUL_H - 1);
  localparam logic [9:0] C_BUL_V     = 10'(BUL_V);
  localparam logic [9:0] C_OBS_W1    = 10'(OBS_W - 1);
  localparam logic [9:0] C_OBS_H1    = 10'(OBS_H - 1);
  localparam logic [9:0] C_OBS_V0    = 10'(OBS_V0);
  localparam logic [9:0] C_OBS_RANGE = 10'(MAX_X - OBS_W);
  localparam logic [9:0] C_SEED      = 10'h1A5;
  localparam logic [9:0] C_OBS_X0    = 10'(32'h1A5 % (MAX_X - OBS_W));
  localparam logic [NUM_BUL-1:0] C_NB_ONE = NUM_BUL'(1);

  // LFSR value is below 2*(MAX_X-OBS_W), so one conditional subtract is a full modulo.
  function automatic logic [9:0] wrap_x(input logic [9:0] v);
    return (v >= C_OBS_RANGE) ? v - C_OBS_RANGE : v;
  endfunction

  state_t                state_q, state_d;
  logic [1:0]            life_q, life_d;
  logic [1:0]            level_q, level_d;
  logic [4*DIGITS-1:0]   score_q, score_d;
  logic [9:0]            gun_x_q, gun_x_d;
  logic [NUM_BUL-1:0]    bul_v_q, bul_v_d;
  logic [9:0]            bul_x_q [NUM_BUL];
  logic [9:0]            bul_x_d [NUM_BUL];
  logic [9:0]            bul_t_q [NUM_BUL];
  logic [9:0]            bul_t_d [NUM_BUL];
  logic [9:0]            obs_x_q, obs_x_d;
  logic [9:0]            obs_y_q, obs_y_d;
  logic [9:0]            lfsr_q, lfsr_d;
  logic                  fire_pend_q, fire_pend_d;
  logic [2:0]            rgb_q, rgb_d;

  logic                  refr_tick;
  logic                  fire_key;
  logic                  auto_fire;
  logic                  fire_req;
  logic [NUM_BUL-1:0]    ov;
  logic [NUM_BUL-1:0]    hit_sel;
  logic [NUM_BUL-1:0]    alloc_sel;
  logic [9:0]            obs_y_mv;
  logic                  carry;
  logic                  bul_px, obs_px, gun_px;

`ifdef SHOOTER_AUTOFIRE_EN
  localparam int AW = (AUTO_PER > 1) ? $clog2(AUTO_PER) : 1;
  logic [AW-1:0] auto_cnt_q, auto_cnt_d;
  logic          auto_held;

  // Counter is zero on the first held tick, so that tick fires (merging with
  // the press pulse) and then every AUTO_PER ticks after it.
  always_comb begin
    auto_held  = (key == 5'h15) && (state_q == ST_PLAY);
    auto_fire  = auto_held && (auto_cnt_q == '0);
    auto_cnt_d = auto_cnt_q;
    if (!auto_held) begin
      auto_cnt_d = '0;
    end else if (refr_tick) begin
      auto_cnt_d = (auto_cnt_q == AW'(AUTO_PER - 1)) ? '0 : auto_cnt_q + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) auto_cnt_q <= '0;
    else     auto_cnt_q <= auto_cnt_d;
  end
`else
  assign auto_fire = 1'b0;
`endif

  assign refr_tick = (x == C_XLAST) && (y == C_YLAST);
  assign fire_key  = (key_pulse == 5'h15) && (state_q == ST_PLAY);
  assign fire_req  = fire_pend_q | fire_key | auto_fire;

  // Hit test on pre-move positions; x & ~(x-1) isolates the lowest set bit.
  always_comb begin
    for (int i = 0; i < NUM_BUL; i++) begin
      ov[i] = bul_v_q[i] &&
              (bul_x_q[i] <= obs_x_q + C_OBS_W1) && (obs_x_q <= bul_x_q[i] + C_BUL_W1) &&
              (bul_t_q[i] <= obs_y_q + C_OBS_H1) && (obs_y_q <= bul_t_q[i] + C_BUL_H1);
    end
    hit_sel   = ov & ~(ov - C_NB_ONE);
    // Only slots free before this tick are eligible, so a slot freed now waits a frame.
    alloc_sel = ~bul_v_q & ~(~bul_v_q - C_NB_ONE);
  end

  always_comb begin
    state_d     = state_q;
    life_d      = life_q;
    level_d     = level_q;
    score_d     = score_q;
    gun_x_d     = gun_x_q;
    bul_v_d     = bul_v_q;
    bul_x_d     = bul_x_q;
    bul_t_d     = bul_t_q;
    obs_x_d     = obs_x_q;
    obs_y_d     = obs_y_q;
    carry       = 1'b1;
    obs_y_mv    = obs_y_q + C_OBS_V0 + {8'd0, level_q};
    lfsr_d      = refr_tick ? {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]} : lfsr_q;
    fire_pend_d = (refr_tick || state_q != ST_PLAY) ? 1'b0 : (fire_pend_q | fire_key);

    case (state_q)
      ST_NEWGAME: begin
        score_d = '0;
        life_d  = 2'(LIVES);
        level_d = 2'd0;
        if (key_pulse[4]) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (refr_tick) begin
          for (int i = 0; i < NUM_BUL; i++) begin
            if (bul_v_q[i]) begin
              if (hit_sel[i] || bul_t_q[i] < C_BUL_V) bul_v_d[i] = 1'b0;
              else                                    bul_t_d[i] = bul_t_q[i] - C_BUL_V;
            end
            if (fire_req && alloc_sel[i]) begin
              bul_v_d[i] = 1'b1;
              bul_x_d[i] = gun_x_q + C_BUL_XOFF;
              bul_t_d[i] = C_BUL_TOP0;
            end
          end

          if (key == 5'h11 && gun_x_q + C_GUN_W1 <= C_XLAST - C_GUN_V) gun_x_d = gun_x_q + C_GUN_V;
          else if (key == 5'h13 && gun_x_q >= C_GUN_V)                  gun_x_d = gun_x_q - C_GUN_V;

          if (|hit_sel) begin
            obs_x_d = wrap_x(lfsr_q);
            obs_y_d = '0;
            for (int d = 0; d < DIGITS; d++) begin
              if (carry) begin
                if (score_q[4*d +: 4] == 4'd9) begin
                  score_d[4*d +: 4] = 4'd0;
                end else begin
                  score_d[4*d +: 4] = score_q[4*d +: 4] + 4'd1;
                  carry = 1'b0;
                end
              end
            end
            if (score_q[3:0] == 4'd9 && level_q != 2'd3) level_d = level_q + 2'd1;
          end else if (obs_y_mv + C_OBS_H1 >= C_YLAST) begin
            // Miss: respawn everything for the next gun.
            obs_x_d = wrap_x(lfsr_q);
            obs_y_d = '0;
            gun_x_d = C_GUN_X0;
            bul_v_d = '0;
            if (life_q == 2'd1) begin
              life_d  = 2'd0;
              state_d = ST_OVER;
            end else begin
              life_d  = life_q - 2'd1;
              state_d = ST_NEWGUN;
            end
          end else begin
            obs_y_d = obs_y_mv;
          end
        end
      end
      ST_NEWGUN: begin
        if (key_pulse[4]) state_d = ST_PLAY;
      end
      default: begin
        if (key_pulse[4]) state_d = ST_NEWGAME;
      end
    endcase
  end

  always_comb begin
    bul_px = 1'b0;
    for (int i = 0; i < NUM_BUL; i++) begin
      if (bul_v_q[i] && x >= bul_x_q[i] && x <= bul_x_q[i] + C_BUL_W1 &&
          y >= bul_t_q[i] && y <= bul_t_q[i] + C_BUL_H1) bul_px = 1'b1;
    end
    obs_px = (x >= obs_x_q) && (x <= obs_x_q + C_OBS_W1) && (y >= obs_y_q) && (y <= obs_y_q + C_OBS_H1);
    gun_px = (x >= gun_x_q) && (x <= gun_x_q + C_GUN_W1) && (y >= C_GUN_YT) && (y <= C_GUN_YB);
    if (bul_px)      rgb_d = 3'b110;
    else if (obs_px) rgb_d = 3'b100;
    else if (gun_px) rgb_d = 3'b111;
    else             rgb_d = 3'b000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_NEWGAME;
      life_q      <= 2'd0;
      level_q     <= 2'd0;
      score_q     <= '0;
      gun_x_q     <= C_GUN_X0;
      bul_v_q     <= '0;
      for (int i = 0; i < NUM_BUL; i++) begin
        bul_x_q[i] <= '0;
        bul_t_q[i] <= '0;
      end
      obs_x_q     <= C_OBS_X0;
      obs_y_q     <= '0;
      lfsr_q      <= C_SEED;
      fire_pend_q <= 1'b0;
      rgb_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      life_q      <= life_d;
      level_q     <= level_d;
      score_q     <= score_d;
      gun_x_q     <= gun_x_d;
      bul_v_q     <= bul_v_d;
      bul_x_q     <= bul_x_d;
      bul_t_q     <= bul_t_d;
      obs_x_q     <= obs_x_d;
      obs_y_q     <= obs_y_d;
      lfsr_q      <= lfsr_d;
      fire_pend_q <= fire_pend_d;
      rgb_q       <= rgb_d;
    end
  end

  assign rgb       = rgb_q;
  assign score_bcd = score_q;
  assign life      = life_q;
  assign level     = level_q;
  assign state     = state_q;
  assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_shooter_core.sv
// tb/tb_shooter_core.sv - randomized bench for shooter_core against a frame-level game model
module tb_shooter_core;

  localparam int MX = 640, MY = 480, GW = 50, GYT = 420, GYB = 470, GV = 4;
  localparam int NB = 4, BW = 4, BH = 8, BV = 8, OW = 32, OH = 16, OV0 = 1;
  localparam int LIV = 3, APER = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] x = '0, y = '0;
  logic [4:0] key = '0, key_pulse = '0;
  logic [2:0] rgb;
  logic [7:0] score_bcd;
  logic [1:0] life, level, state;
  logic       game_over;

  int n_chk = 0, n_fail = 0;

  // game model
  int st, lf, lv, sc, gx, ox, oy, lfsr, af_cnt;
  bit pend;
  bit bv [NB];
  int bx [NB], bt [NB];

  shooter_core dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .key(key), .key_pulse(key_pulse),
    .rgb(rgb), .score_bcd(score_bcd), .life(life), .level(level),
    .state(state), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    st = 0; lf = LIV; lv = 0; sc = 0; gx = (MX - GW) / 2;
    lfsr = 'h1A5; ox = 'h1A5 % (MX - OW); oy = 0; pend = 0; af_cnt = 0;
    for (int i = 0; i < NB; i++) begin bv[i] = 0; bx[i] = 0; bt[i] = 0; end
  endtask

  function automatic int lfsr_next(int v);
    return ((v << 1) & 1023) | (((v >> 9) ^ (v >> 6)) & 1);
  endfunction

  function automatic bit touches(int i);
    return bx[i] < ox + OW && ox < bx[i] + BW && bt[i] < oy + OH && oy < bt[i] + BH;
  endfunction

  function automatic int m_pix(int px, int py);
    for (int i = 0; i < NB; i++)
      if (bv[i] && px >= bx[i] && px < bx[i] + BW && py >= bt[i] && py < bt[i] + BH) return 6;
    if (px >= ox && px < ox + OW && py >= oy && py < oy + OH) return 4;
    if (px >= gx && px < gx + GW && py >= GYT && py <= GYB) return 7;
    return 0;
  endfunction

  task automatic m_pulse(input logic [4:0] p);
    if (p == 5'h15 && st == 1) pend = 1;
    if (p[4]) begin
      if (st == 0 || st == 2) st = 1;
      else if (st == 3) begin st = 0; sc = 0; lf = LIV; lv = 0; end
    end
  endtask

  task automatic m_tick(input logic [4:0] k);
    int hit, ny, lpre;
    bit fire, af;
    bit was [NB];
    lpre = lfsr;
    lfsr = lfsr_next(lfsr);
    af = 0;
`ifdef SHOOTER_AUTOFIRE_EN
    if (k == 5'h15 && st == 1) begin
      af = (af_cnt == 0);
      af_cnt = (af_cnt + 1) % APER;
    end else af_cnt = 0;
`endif
    if (st == 1) begin
      fire = pend || af;
      hit = -1;
      for (int i = 0; i < NB; i++) begin
        was[i] = bv[i];
        if (hit < 0 && bv[i] && touches(i)) hit = i;
      end
      for (int i = 0; i < NB; i++)
        if (bv[i]) begin
          if (i == hit || bt[i] < BV) bv[i] = 0;
          else bt[i] -= BV;
        end
      if (fire)
        for (int i = 0; i < NB; i++)
          if (!was[i]) begin
            bv[i] = 1; bx[i] = gx + (GW - BW) / 2; bt[i] = GYT - BH;
            break;
          end
      if (k == 5'h11 && gx + GW - 1 <= MX - 1 - GV) gx += GV;
      else if (k == 5'h13 && gx >= GV) gx -= GV;
      if (hit >= 0) begin
        ox = lpre % (MX - OW); oy = 0;
        if (sc % 10 == 9 && lv < 3) lv++;
        sc = (sc + 1) % 100;
      end else begin
        ny = oy + OV0 + lv;
        if (ny + OH - 1 >= MY - 1) begin
          ox = lpre % (MX - OW); oy = 0; gx = (MX - GW) / 2;
          for (int i = 0; i < NB; i++) bv[i] = 0;
          if (lf == 1) begin lf = 0; st = 3; end
          else begin lf--; st = 2; end
        end else oy = ny;
      end
    end
    pend = 0;
    if (st != 1) af_cnt = 0;
  endtask

  task automatic probe(input int px, input int py);
    if (px < 0 || px >= MX || py < 0 || py >= MY || (px == MX - 1 && py == MY - 1)) return;
    x = 10'(px); y = 10'(py);
    clk1();
    chk($sformatf("rgb@%0d,%0d", px, py), int'(rgb), m_pix(px, py));
  endtask

  task automatic frame(input logic [4:0] k, input logic [4:0] p);
    key = k; x = '0; y = '0;
    if (p != 5'h00) begin
      key_pulse = p;
      clk1();
      m_pulse(p);
      key_pulse = '0;
    end
    x = 10'(MX - 1); y = 10'(MY - 1);
    clk1();
    m_tick(k);
    probe(gx, GYT);
    probe(gx + GW - 1, GYB);
    probe(gx + GW, 445);
    probe(gx - 1, 445);
    probe(ox, oy);
    probe(ox + OW - 1, oy + OH - 1);
    probe(ox + OW, oy);
    for (int i = 0; i < NB; i++)
      if (bv[i]) begin
        probe(bx[i], bt[i]);
        probe(bx[i] + BW - 1, bt[i] + BH - 1);
      end
    probe(int'($urandom_range(0, MX - 1)), int'($urandom_range(0, MY - 2)));
    chk("state", int'(state), st);
    chk("life", int'(life), lf);
    chk("level", int'(level), lv);
    chk("score", int'(score_bcd), ((sc / 10) % 10) * 16 + sc % 10);
    chk("game_over", int'(game_over), int'(st == 3));
  endtask

  task automatic reset_checks(input string sfx);
    chk({"rst_state", sfx}, int'(state), 0);
    chk({"rst_score", sfx}, int'(score_bcd), 0);
    chk({"rst_life", sfx}, int'(life), 0);
    chk({"rst_level", sfx}, int'(level), 0);
    chk({"rst_rgb", sfx}, int'(rgb), 0);
    chk({"rst_over", sfx}, int'(game_over), 0);
  endtask

  initial begin
    logic [4:0] k, p;
    int tgt;
    m_reset();
    repeat (3) clk1();
    reset_checks("");
    rst = 1'b0;
    clk1();

    frame(5'h00, 5'h00);
    frame(5'h00, 5'h10);
    for (int f = 0; f < 10; f++) frame(5'h11, 5'h00);
    for (int f = 0; f < 5; f++) frame(5'h00, 5'h15);
    for (int f = 0; f < 80; f++) frame(5'h11, (f % 3 == 0) ? 5'h15 : 5'h00);

    // steer under the obstacle and fire often to build score and level
    for (int f = 0; f < 1200; f++) begin
      tgt = ox - 8;
      if ($urandom_range(0, 99) < 20) k = 5'(($urandom_range(0, 3) == 0) ? 5'h13 : 5'h11);
      else if (gx < tgt - 2) k = 5'h11;
      else if (gx > tgt + 2) k = 5'h13;
      else k = 5'h00;
      p = 5'h00;
      if (st != 1) p = 5'h10;
      else if ($urandom_range(0, 99) < 45) p = 5'h15;
      frame(k, p);
    end

    // no firing: misses drain lives through NEWGUN to OVER and restart
    for (int f = 0; f < 700; f++) begin
      case ($urandom_range(0, 2))
        0: k = 5'h11;
        1: k = 5'h13;
        default: k = 5'h00;
      endcase
      p = (st != 1 && $urandom_range(0, 9) == 0) ? 5'h10 : 5'h00;
      frame(k, p);
    end

    // asynchronous reset in the middle of play with bullets in flight
    for (int f = 0; f < 3; f++) if (st != 1) frame(5'h00, 5'h10);
    frame(5'h00, 5'h15);
    frame(5'h00, 5'h15);
    frame(5'h00, 5'h00);
    x = 10'd5; y = 10'd5;
    #2 rst = 1'b1;
    #1 reset_checks("_mid");
    m_reset();
    clk1();
    rst = 1'b0;
    clk1();
    frame(5'h00, 5'h00);
    frame(5'h00, 5'h10);
    frame(5'h00, 5'h15);
    frame(5'h00, 5'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
